// File: rtl/immgen_stage.sv
// Decode-stage immediate generator: RV32I/RV64I immediate, format code and pc+imm.
// Latency: one cycle from input handshake to registered output.
// Backpressure: out_* held while stalled; SKID=1 adds a second entry so in_ready comes from a flop.
module immgen_stage #(
  parameter int XLEN    = 32,
  parameter bit CSR_IMM = 1'b1,
  parameter bit SKID    = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_pc_imm,
  output logic            out_illegal
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;

  // One decoded instruction, as it sits in the output or skid register.
  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic [XLEN-1:0] pc_imm;
    logic            illegal;
  } res_t;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // ---------------------------------------------------------------------------
  // Input-side decode
  // ---------------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];

  // Every candidate immediate is built as a 32-bit value already sign-extended
  // to 32 bits; the final widening to XLEN is a single signed cast below.
  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};
  assign imm_z = {27'b0, in_instr[19:15]};

  logic [31:0]     imm32;
  fmt_e            dec_fmt;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] dec_pc_imm;
  res_t            dec_res;

  // Opcode -> format selection; unknown opcodes yield illegal with a zero immediate.
  always_comb begin
    imm32       = '0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        dec_fmt = FMT_U;
        imm32   = imm_u;
      end
      OPC_JAL: begin
        dec_fmt = FMT_J;
        imm32   = imm_j;
      end
      OPC_JALR, OPC_OP_IMM, OPC_LOAD: begin
        dec_fmt = FMT_I;
        imm32   = imm_i;
      end
      OPC_OP_IMM32: begin
        if (XLEN == 64) begin
          dec_fmt = FMT_I;
          imm32   = imm_i;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        dec_fmt = FMT_S;
        imm32   = imm_s;
      end
      OPC_BRANCH: begin
        dec_fmt = FMT_B;
        imm32   = imm_b;
      end
      OPC_OP, OPC_MISC_MEM: begin
        dec_fmt = FMT_NONE;
      end
      OPC_OP32: begin
        if (XLEN != 64) begin
          dec_illegal = 1'b1;
        end
      end
      OPC_SYSTEM: begin
        // funct3 == 000 is ECALL/EBREAK/xRET: no immediate at all.
        if (funct3 != 3'b000) begin
          if (CSR_IMM) begin
            dec_fmt = FMT_Z;
            imm32   = imm_z;
          end else begin
            dec_fmt = FMT_I;
            imm32   = imm_i;
          end
        end
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // zimm has bit 31 clear, so the signed widening is also a correct zero-extension.
  assign dec_imm    = XLEN'($signed(imm32));
  assign dec_pc_imm = in_pc + dec_imm;

  // Bundle the decoded fields with the passthrough fields for registering.
  always_comb begin
    dec_res         = '0;
    dec_res.instr   = in_instr;
    dec_res.pc      = in_pc;
    dec_res.imm     = dec_imm;
    dec_res.fmt     = dec_fmt;
    dec_res.pc_imm  = dec_pc_imm;
    dec_res.illegal = dec_illegal;
  end

  // ---------------------------------------------------------------------------
  // Output staging
  // ---------------------------------------------------------------------------
  res_t out_q;
  logic out_vld_q;
  logic out_free;

  // The output register may load this cycle if it is empty or being consumed.
  assign out_free = !out_vld_q || out_ready;

  generate
    if (SKID) begin : g_skid
      res_t skid_q;
      logic skid_full_q;

      // Registered ready: with the skid empty there is always room for one more.
      assign in_ready = !skid_full_q;

      // Output + skid registers; skid only fills when the output is stalled.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_q       <= '0;
          out_vld_q   <= 1'b0;
          skid_q      <= '0;
          skid_full_q <= 1'b0;
        end else if (skid_full_q) begin
          // in_ready is low here, so only the drain side can move.
          if (out_free) begin
            out_q       <= skid_q;
            skid_full_q <= 1'b0;
          end
        end else if (in_valid) begin
          if (out_free) begin
            out_q     <= dec_res;
            out_vld_q <= 1'b1;
          end else begin
            skid_q      <= dec_res;
            skid_full_q <= 1'b1;
          end
        end else if (out_ready) begin
          out_vld_q <= 1'b0;
        end
      end
    end else begin : g_noskid
      // Combinational ready: accept whenever the single register frees up.
      assign in_ready = out_free;

      // Single output register; a new accept overwrites a consumed entry.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_q     <= '0;
          out_vld_q <= 1'b0;
        end else if (in_valid && out_free) begin
          out_q     <= dec_res;
          out_vld_q <= 1'b1;
        end else if (out_ready) begin
          out_vld_q <= 1'b0;
        end
      end
    end
  endgenerate

  assign out_valid   = out_vld_q;
  assign out_instr   = out_q.instr;
  assign out_pc      = out_q.pc;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_pc_imm  = out_q.pc_imm;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_immgen_stage.sv
// Bench for immgen_stage: a 32-bit skid instance and a 64-bit no-skid instance.
// Directed vectors plus a randomized stream scored against a reference decoder.
// Inputs driven at negedge, outputs sampled 1 time unit later.
module tb_immgen_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance A: XLEN=32, CSR_IMM=1, SKID=1
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
  logic [31:0] a_in_instr, a_in_pc, a_out_instr, a_out_pc, a_out_imm, a_out_pc_imm;
  logic [2:0]  a_out_fmt;
  // Instance B: XLEN=64, CSR_IMM=0, SKID=0
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
  logic [31:0] b_in_instr, b_out_instr;
  logic [63:0] b_in_pc, b_out_pc, b_out_imm, b_out_pc_imm;
  logic [2:0]  b_out_fmt;

  immgen_stage #(.XLEN(32), .CSR_IMM(1'b1), .SKID(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr), .in_pc(a_in_pc),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_instr(a_out_instr),
    .out_pc(a_out_pc), .out_imm(a_out_imm), .out_fmt(a_out_fmt),
    .out_pc_imm(a_out_pc_imm), .out_illegal(a_out_illegal)
  );

  immgen_stage #(.XLEN(64), .CSR_IMM(1'b0), .SKID(1'b0)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_pc(b_in_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_instr(b_out_instr),
    .out_pc(b_out_pc), .out_imm(b_out_imm), .out_fmt(b_out_fmt),
    .out_pc_imm(b_out_pc_imm), .out_illegal(b_out_illegal)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  // ---------------- reference model (plain arithmetic on bit fields) ----------------
  function automatic longint fld(logic [31:0] i, int hi, int lo);
    longint v;
    v = longint'(i);
    return (v >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
  endfunction

  function automatic longint sext(longint v, int bits);
    if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
    return v;
  endfunction

  function automatic exp_t model(logic [31:0] i, logic [63:0] pc, bit x64, bit csr);
    exp_t   e;
    longint v;
    v = 0;
    e.instr = i; e.pc = pc; e.fmt = 3'd0; e.ill = 1'b0;
    case (i[6:0])
      7'h37, 7'h17: begin v = sext(fld(i, 31, 12), 20) * 4096; e.fmt = 3'd4; end
      7'h6F: begin
        v = sext(fld(i, 31, 31) * (1 << 20) + fld(i, 19, 12) * 4096 +
                 fld(i, 20, 20) * 2048 + fld(i, 30, 21) * 2, 21);
        e.fmt = 3'd5;
      end
      7'h67, 7'h13, 7'h03: begin v = sext(fld(i, 31, 20), 12); e.fmt = 3'd1; end
      7'h1B: begin
        if (x64) begin v = sext(fld(i, 31, 20), 12); e.fmt = 3'd1; end
        else e.ill = 1'b1;
      end
      7'h23: begin v = sext(fld(i, 31, 25) * 32 + fld(i, 11, 7), 12); e.fmt = 3'd2; end
      7'h63: begin
        v = sext(fld(i, 31, 31) * 4096 + fld(i, 7, 7) * 2048 +
                 fld(i, 30, 25) * 32 + fld(i, 11, 8) * 2, 13);
        e.fmt = 3'd3;
      end
      7'h33, 7'h0F: ;
      7'h3B: if (!x64) e.ill = 1'b1;
      7'h73: begin
        if (fld(i, 14, 12) != 0) begin
          if (csr) begin v = fld(i, 19, 15); e.fmt = 3'd6; end
          else begin v = sext(fld(i, 31, 20), 12); e.fmt = 3'd1; end
        end
      end
      default: e.ill = 1'b1;
    endcase
    e.imm = x64 ? 64'(v) : {32'b0, 32'(v)};
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  op;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0: op = 7'h37;  1: op = 7'h17;  2: op = 7'h6F;  3: op = 7'h67;
      4: op = 7'h13;  5: op = 7'h03;  6: op = 7'h1B;  7: op = 7'h23;
      8: op = 7'h63;  9: op = 7'h33; 10: op = 7'h0F; 11: op = 7'h3B;
      12: op = 7'h73; 13: op = 7'h73;
      default: op = r[6:0];
    endcase
    return {r[31:7], op};
  endfunction

  task automatic idle();
    a_in_valid = 1'b0; a_in_instr = '0; a_in_pc = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_instr = '0; b_in_pc = '0; b_out_ready = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; idle(); b_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; #1;
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL reset_a_out_valid got=%0b exp=0", a_out_valid); else n_pass++;
    n_total++; if (a_in_ready !== 1'b1) $display("FAIL reset_a_in_ready got=%0b exp=1", a_in_ready); else n_pass++;
    n_total++; if ({a_out_instr, a_out_pc, a_out_imm, a_out_fmt, a_out_pc_imm, a_out_illegal} !== '0)
      $display("FAIL reset_a_fields got_imm=%h got_instr=%h exp=0", a_out_imm, a_out_instr); else n_pass++;
    n_total++; if (b_out_valid !== 1'b0) $display("FAIL reset_b_out_valid got=%0b exp=0", b_out_valid); else n_pass++;
    n_total++; if (b_in_ready !== 1'b1) $display("FAIL reset_b_in_ready got=%0b exp=1", b_in_ready); else n_pass++;
    n_total++; if ({b_out_instr, b_out_pc, b_out_imm, b_out_fmt, b_out_pc_imm, b_out_illegal} !== '0)
      $display("FAIL reset_b_fields got_imm=%h exp=0", b_out_imm); else n_pass++;
    b_out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed_a();
    logic [31:0] t_instr [5] = '{32'h123450B7, 32'hFFDFF0EF, 32'hFE512E23, 32'h3002D073, 32'h00000000};
    logic [31:0] t_pc    [5] = '{32'h0, 32'h100, 32'h200, 32'h40, 32'h80};
    logic [31:0] t_imm   [5] = '{32'h12345000, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h5, 32'h0};
    logic [2:0]  t_fmt   [5] = '{3'd4, 3'd5, 3'd2, 3'd6, 3'd0};
    logic        t_ill   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] pcimm;
    idle();
    for (int k = 0; k < 5; k++) begin
      a_in_valid = 1'b1; a_in_instr = t_instr[k]; a_in_pc = t_pc[k]; #1;
      n_total++; if (a_in_ready !== 1'b1) $display("FAIL dir_a_in_ready[%0d] got=%0b exp=1", k, a_in_ready); else n_pass++;
      @(negedge clk); a_in_valid = 1'b0; #1;
      pcimm = t_pc[k] + t_imm[k];
      n_total++; if (a_out_valid !== 1'b1) $display("FAIL dir_a_valid[%0d] got=%0b exp=1", k, a_out_valid); else n_pass++;
      n_total++; if (a_out_imm !== t_imm[k]) $display("FAIL dir_a_imm[%0d] got=%h exp=%h", k, a_out_imm, t_imm[k]); else n_pass++;
      n_total++; if (a_out_fmt !== t_fmt[k]) $display("FAIL dir_a_fmt[%0d] got=%0d exp=%0d", k, a_out_fmt, t_fmt[k]); else n_pass++;
      n_total++; if (a_out_illegal !== t_ill[k]) $display("FAIL dir_a_ill[%0d] got=%0b exp=%0b", k, a_out_illegal, t_ill[k]); else n_pass++;
      n_total++; if (a_out_pc_imm !== pcimm) $display("FAIL dir_a_pc_imm[%0d] got=%h exp=%h", k, a_out_pc_imm, pcimm); else n_pass++;
      n_total++; if ({a_out_instr, a_out_pc} !== {t_instr[k], t_pc[k]})
        $display("FAIL dir_a_pass[%0d] got=%h/%h exp=%h/%h", k, a_out_instr, a_out_pc, t_instr[k], t_pc[k]); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_directed_b();
    logic [31:0] t_instr [5] = '{32'h800000B7, 32'h3002D073, 32'hFFF1009B, 32'h002081BB, 32'h00000073};
    logic [63:0] t_imm   [5] = '{64'hFFFFFFFF80000000, 64'h300, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0};
    logic [2:0]  t_fmt   [5] = '{3'd4, 3'd1, 3'd1, 3'd0, 3'd0};
    logic [63:0] pc, pcimm;
    idle();
    for (int k = 0; k < 5; k++) begin
      pc = 64'h0000_0001_0000_1000 + 64'(k * 4);
      b_in_valid = 1'b1; b_in_instr = t_instr[k]; b_in_pc = pc;
      @(negedge clk); b_in_valid = 1'b0; #1;
      pcimm = pc + t_imm[k];
      n_total++; if (b_out_valid !== 1'b1) $display("FAIL dir_b_valid[%0d] got=%0b exp=1", k, b_out_valid); else n_pass++;
      n_total++; if (b_out_imm !== t_imm[k]) $display("FAIL dir_b_imm[%0d] got=%h exp=%h", k, b_out_imm, t_imm[k]); else n_pass++;
      n_total++; if ({b_out_fmt, b_out_illegal} !== {t_fmt[k], 1'b0})
        $display("FAIL dir_b_fmt[%0d] got=%0d/%0b exp=%0d/0", k, b_out_fmt, b_out_illegal, t_fmt[k]); else n_pass++;
      n_total++; if (b_out_pc_imm !== pcimm) $display("FAIL dir_b_pc_imm[%0d] got=%h exp=%h", k, b_out_pc_imm, pcimm); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_comb_ready();
    idle();
    b_in_valid = 1'b1; b_in_instr = 32'h00100093; b_in_pc = 64'h0; b_out_ready = 1'b0; #1;
    n_total++; if (b_in_ready !== 1'b1) $display("FAIL comb_ready_empty got=%0b exp=1", b_in_ready); else n_pass++;
    @(negedge clk); b_in_valid = 1'b0; #1;
    n_total++; if (b_out_valid !== 1'b1) $display("FAIL comb_ready_valid got=%0b exp=1", b_out_valid); else n_pass++;
    n_total++; if (b_in_ready !== 1'b0) $display("FAIL comb_ready_stalled got=%0b exp=0", b_in_ready); else n_pass++;
    b_out_ready = 1'b1; #1;
    n_total++; if (b_in_ready !== 1'b1) $display("FAIL comb_ready_release got=%0b exp=1", b_in_ready); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (b_out_valid !== 1'b0) $display("FAIL comb_ready_drained got=%0b exp=0", b_out_valid); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [31:0]  instrs [6];
    exp_t         q[$];
    exp_t         e;
    int           idx, got;
    logic         stall;
    logic [131:0] snap, now, want;
    logic [31:0]  pcimm;
    idle();
    for (int k = 0; k < 6; k++) instrs[k] = rand_instr();
    idx = 0; got = 0; stall = 1'b0; snap = '0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      a_out_ready = (cyc >= 3);
      a_in_valid  = (idx < 6);
      a_in_instr  = instrs[idx < 6 ? idx : 5];
      a_in_pc     = 32'h1000 + 32'(idx * 4);
      #1;
      now = {a_out_instr, a_out_pc, a_out_imm, a_out_fmt, a_out_illegal, a_out_pc_imm};
      if (cyc == 2) begin
        n_total++; if (a_in_ready !== 1'b0) $display("FAIL bp_ready_drop got=%0b exp=0", a_in_ready); else n_pass++;
        n_total++; if (idx != 2) $display("FAIL bp_accepts_before_drop got=%0d exp=2", idx); else n_pass++;
      end
      if (stall) begin
        n_total++; if (now !== snap) $display("FAIL bp_stable cyc=%0d got=%h exp=%h", cyc, now, snap); else n_pass++;
      end
      if (a_out_valid && a_out_ready) begin
        n_total++;
        if (q.size() == 0) $display("FAIL bp_unexpected_output got=%h exp=none", a_out_instr);
        else begin
          e = q.pop_front();
          pcimm = e.pc[31:0] + e.imm[31:0];
          want = {e.instr, e.pc[31:0], e.imm[31:0], e.fmt, e.ill, pcimm};
          if (now !== want) $display("FAIL bp_order[%0d] got=%h exp=%h", got, now, want); else n_pass++;
        end
        got++;
      end
      if (a_in_valid && a_in_ready) begin
        q.push_back(model(a_in_instr, {32'b0, a_in_pc}, 1'b0, 1'b1));
        idx++;
      end
      stall = a_out_valid && !a_out_ready;
      snap  = now;
      @(negedge clk);
    end
    n_total++; if (got != 6 || q.size() != 0) $display("FAIL bp_count got=%0d left=%0d exp=6/0", got, q.size()); else n_pass++;
    idle();
    @(negedge clk);
  endtask

  task automatic test_throughput();
    logic [31:0] instrs [10];
    int          a_acc, b_acc, a_got, b_got;
    idle();
    for (int k = 0; k < 10; k++) instrs[k] = rand_instr();
    a_acc = 0; b_acc = 0; a_got = 0; b_got = 0;
    for (int cyc = 0; cyc < 11; cyc++) begin
      a_in_valid = (cyc < 10); b_in_valid = (cyc < 10);
      a_in_instr = instrs[cyc < 10 ? cyc : 9]; b_in_instr = a_in_instr;
      a_in_pc = 32'(cyc * 4); b_in_pc = 64'(cyc * 4);
      #1;
      if (a_out_valid) begin
        n_total++; if (a_out_instr !== instrs[a_got]) $display("FAIL tp_a_order[%0d] got=%h exp=%h", a_got, a_out_instr, instrs[a_got]); else n_pass++;
        a_got++;
      end
      if (b_out_valid) begin
        n_total++; if (b_out_instr !== instrs[b_got]) $display("FAIL tp_b_order[%0d] got=%h exp=%h", b_got, b_out_instr, instrs[b_got]); else n_pass++;
        b_got++;
      end
      if (a_in_valid && a_in_ready) a_acc++;
      if (b_in_valid && b_in_ready) b_acc++;
      @(negedge clk);
    end
    n_total++; if (a_acc != 10 || a_got != 10) $display("FAIL tp_a_rate acc=%0d out=%0d exp=10/10", a_acc, a_got); else n_pass++;
    n_total++; if (b_acc != 10 || b_got != 10) $display("FAIL tp_b_rate acc=%0d out=%0d exp=10/10", b_acc, b_got); else n_pass++;
    idle();
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    idle();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_instr = 32'h111110B7; a_in_pc = 32'h10;
    @(negedge clk); a_in_instr = 32'h22222137; a_in_pc = 32'h14;
    @(negedge clk); a_in_instr = 32'h33333037; #1;
    n_total++; if (a_in_ready !== 1'b0) $display("FAIL mr_skid_full got=%0b exp=0", a_in_ready); else n_pass++;
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; a_in_valid = 1'b0; #1;
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL mr_out_valid got=%0b exp=0", a_out_valid); else n_pass++;
    n_total++; if (a_in_ready !== 1'b1) $display("FAIL mr_in_ready got=%0b exp=1", a_in_ready); else n_pass++;
    n_total++; if ({a_out_instr, a_out_imm} !== 64'h0) $display("FAIL mr_fields got=%h/%h exp=0", a_out_instr, a_out_imm); else n_pass++;
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_instr = 32'hABCDE0B7; a_in_pc = 32'h300;
    @(negedge clk); a_in_valid = 1'b0; #1;
    n_total++; if ({a_out_valid, a_out_instr, a_out_imm, a_out_pc_imm} !== {1'b1, 32'hABCDE0B7, 32'hABCDE000, 32'hABCDE300})
      $display("FAIL mr_new_lui got=%0b/%h/%h/%h exp=1/abcde0b7/abcde000/abcde300", a_out_valid, a_out_instr, a_out_imm, a_out_pc_imm);
    else n_pass++;
    @(negedge clk); #1;
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL mr_no_stale got=%0b exp=0", a_out_valid); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_random_stream();
    exp_t         qa[$], qb[$];
    exp_t         e;
    logic         drain, a_stall, b_stall;
    logic [131:0] a_snap, a_now, a_want;
    logic [227:0] b_snap, b_now, b_want;
    logic [31:0]  pa;
    logic [63:0]  pb;
    a_stall = 1'b0; b_stall = 1'b0; a_snap = '0; b_snap = '0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      drain = (cyc >= 400);
      a_in_valid  = !drain && ($urandom_range(0, 9) < 7);
      a_in_instr  = rand_instr();
      a_in_pc     = $urandom;
      a_out_ready = drain || ($urandom_range(0, 9) < 6);
      b_in_valid  = !drain && ($urandom_range(0, 9) < 7);
      b_in_instr  = rand_instr();
      b_in_pc     = {$urandom, $urandom};
      b_out_ready = drain || ($urandom_range(0, 9) < 6);
      #1;
      a_now = {a_out_instr, a_out_pc, a_out_imm, a_out_fmt, a_out_illegal, a_out_pc_imm};
      b_now = {b_out_instr, b_out_pc, b_out_imm, b_out_fmt, b_out_illegal, b_out_pc_imm};
      if (a_stall) begin
        n_total++; if (a_now !== a_snap) $display("FAIL rnd_a_stable cyc=%0d got=%h exp=%h", cyc, a_now, a_snap); else n_pass++;
      end
      if (b_stall) begin
        n_total++; if (b_now !== b_snap) $display("FAIL rnd_b_stable cyc=%0d got=%h exp=%h", cyc, b_now, b_snap); else n_pass++;
      end
      if (a_out_valid && a_out_ready) begin
        n_total++;
        if (qa.size() == 0) $display("FAIL rnd_a_extra got=%h exp=none", a_out_instr);
        else begin
          e = qa.pop_front();
          pa = e.pc[31:0] + e.imm[31:0];
          a_want = {e.instr, e.pc[31:0], e.imm[31:0], e.fmt, e.ill, pa};
          if (a_now !== a_want) $display("FAIL rnd_a_out cyc=%0d got=%h exp=%h", cyc, a_now, a_want); else n_pass++;
        end
      end
      if (b_out_valid && b_out_ready) begin
        n_total++;
        if (qb.size() == 0) $display("FAIL rnd_b_extra got=%h exp=none", b_out_instr);
        else begin
          e = qb.pop_front();
          pb = e.pc + e.imm;
          b_want = {e.instr, e.pc, e.imm, e.fmt, e.ill, pb};
          if (b_now !== b_want) $display("FAIL rnd_b_out cyc=%0d got=%h exp=%h", cyc, b_now, b_want); else n_pass++;
        end
      end
      if (a_in_valid && a_in_ready) qa.push_back(model(a_in_instr, {32'b0, a_in_pc}, 1'b0, 1'b1));
      if (b_in_valid && b_in_ready) qb.push_back(model(b_in_instr, b_in_pc, 1'b1, 1'b0));
      a_stall = a_out_valid && !a_out_ready; a_snap = a_now;
      b_stall = b_out_valid && !b_out_ready; b_snap = b_now;
      @(negedge clk);
    end
    n_total++; if (qa.size() != 0) $display("FAIL rnd_a_lost left=%0d exp=0", qa.size()); else n_pass++;
    n_total++; if (qb.size() != 0) $display("FAIL rnd_b_lost left=%0d exp=0", qb.size()); else n_pass++;
    idle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_directed_a();
    test_directed_b();
    test_comb_ready();
    test_backpressure();
    test_throughput();
    test_mid_reset();
    test_random_stream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
